instruction_fetch_unit: RTL and testbench

INSTRUCTION_FETCH_UNIT -- requirements
Module: instruction_fetch_unit

---
 rtl/rv32i_pkg.sv | 27 ++
 rtl/ifu_fifo.sv | 62 ++++++
 rtl/instruction_fetch_unit.sv | 145 ++++++++++++++
 tb/tb_instruction_fetch_unit.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32i_pkg.sv
// Shared RV32I fetch-side definitions: IFU state encoding, NOP word, word size, queue entry.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package rv32i_pkg;

  localparam logic [31:0] RV32I_NOP  = 32'h0000_0013;
  localparam logic [31:0] WORD_BYTES = 32'd4;

  typedef enum logic [1:0] {
    IFU_RUN   = 2'd0,
    IFU_DRAIN = 2'd1,
    IFU_HALT  = 2'd2
  } ifu_state_t;

  // One prefetch-queue slot: instruction word, its byte address, misaligned-target marker.
  typedef struct packed {
    logic        fault;
    logic [31:0] pc;
    logic [31:0] inst;
  } ifq_entry_t;

  // Sequential fetch address; wraps modulo 2^32.
  function automatic logic [31:0] next_word_addr(input logic [31:0] addr);
    return addr + WORD_BYTES;
  endfunction

endpackage

// File: rtl/ifu_fifo.sv
// Prefetch queue: power-of-two circular buffer with flush, count, full/empty.
// Latency: a push is visible at the head one cycle later.
// Backpressure: push ignored when full unless a pop happens the same cycle; flush wins over pop.
module ifu_fifo #(
  parameter int W     = 65,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_push,
  input  logic [W-1:0]           i_push_dat,
  input  logic                   i_pop,
  input  logic                   i_flush,
  output logic                   o_full,
  output logic                   o_empty,
  output logic [$clog2(DEPTH):0] o_count,
  output logic [W-1:0]           o_head_dat
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_rd_ptr;
  logic [AW-1:0] r_wr_ptr;
  logic [AW:0]   r_count;
  logic          w_do_push;
  logic          w_do_pop;
  logic [AW-1:0] w_wr_idx;

  assign o_count    = r_count;
  assign o_empty    = (r_count == '0);
  assign o_full     = (r_count == (AW+1)'(DEPTH));
  assign o_head_dat = r_mem[r_rd_ptr];

  assign w_do_pop  = i_pop && !o_empty && !i_flush;
  assign w_do_push = i_push && (i_flush || !o_full || w_do_pop);
  // A push that coincides with a flush lands in slot 0 of the freshly emptied queue.
  assign w_wr_idx  = i_flush ? '0 : r_wr_ptr;

  // Storage write; contents need no reset because the count gates every read.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[w_wr_idx] <= i_push_dat;
  end

  // Pointer and occupancy update; flush restarts at slot 0 and may keep the same-cycle push.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= w_do_push ? AW'(1) : '0;
      r_count  <= w_do_push ? (AW+1)'(1) : '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count <= r_count + (AW+1)'(w_do_push) - (AW+1)'(w_do_pop);
    end
  end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch: sequential word fetch into a prefetch queue, redirect flush with stale-response drain.
// Latency: request accepted in cycle N, response in N+1, word at decode in N+2.
// Backpressure: requests stop while outstanding + queued reaches QUEUE_DEPTH; build option IFU_MISALIGN_CHECK_EN.
module instruction_fetch_unit
  import rv32i_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          QUEUE_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        dec_valid,
  input  logic        dec_ready,
  output logic [31:0] dec_inst,
  output logic [31:0] dec_pc,
  output logic        dec_fault
);

  localparam int          CW      = $clog2(QUEUE_DEPTH) + 1;
  localparam logic [CW:0] DEPTH_W = (CW+1)'(QUEUE_DEPTH);

  ifu_state_t    r_state, w_state_nxt;
  logic [31:0]   r_fetch_pc, w_fetch_pc_nxt;
  logic [31:0]   r_rsp_pc, w_rsp_pc_nxt;
  logic [CW-1:0] r_outstanding, w_outstanding_nxt;
  logic [CW-1:0] w_q_count;
  logic [CW:0]   w_in_flight;
  logic          w_unused_full;
  logic          w_q_empty;
  logic          w_req_fire;
  logic          w_rsp_take;
  logic          w_push;
  logic          w_pop;
  logic          w_misalign;
  logic [31:0]   w_redir_pc;
  ifq_entry_t    w_push_dat;
  ifq_entry_t    w_head;

`ifdef IFU_MISALIGN_CHECK_EN
  assign w_redir_pc = redirect_pc;
  assign w_misalign = (redirect_pc[1:0] != 2'b00);
`else
  // Targets are forced word-aligned, so a fault entry can never be created.
  assign w_redir_pc = redirect_pc & ~32'h3;
  assign w_misalign = 1'b0;
`endif

  assign imem_addr = r_fetch_pc;

  // Next-state, request and queue control; redirect overrides push, pop and PC advance.
  always_comb begin
    w_state_nxt       = r_state;
    w_fetch_pc_nxt    = r_fetch_pc;
    w_rsp_pc_nxt      = r_rsp_pc;
    w_push            = 1'b0;
    w_pop             = 1'b0;
    w_push_dat        = '{fault: 1'b0, pc: r_rsp_pc, inst: imem_rsp_data};
    w_in_flight       = {1'b0, r_outstanding} + {1'b0, w_q_count};
    imem_req_valid    = rst_n && (r_state == IFU_RUN) && (w_in_flight < DEPTH_W);
    w_req_fire        = imem_req_valid && imem_req_ready;
    // A response with nothing outstanding belongs to a request issued before reset.
    w_rsp_take        = imem_rsp_valid && (r_outstanding != '0);
    w_outstanding_nxt = r_outstanding + CW'(w_req_fire) - CW'(w_rsp_take);

    if (redirect_valid) begin
      w_fetch_pc_nxt = w_redir_pc;
      w_rsp_pc_nxt   = w_redir_pc;
      if (w_misalign) begin
        w_push      = 1'b1;
        w_push_dat  = '{fault: 1'b1, pc: w_redir_pc, inst: RV32I_NOP};
        w_state_nxt = IFU_HALT;
      end else if (w_outstanding_nxt != '0) begin
        w_state_nxt = IFU_DRAIN;
      end else begin
        w_state_nxt = IFU_RUN;
      end
    end else begin
      w_pop = !w_q_empty && dec_ready;
      if (w_req_fire) w_fetch_pc_nxt = next_word_addr(r_fetch_pc);
      case (r_state)
        IFU_RUN: begin
          // Outside DRAIN/HALT every outstanding request is live and in address order.
          if (w_rsp_take) begin
            w_push       = 1'b1;
            w_rsp_pc_nxt = next_word_addr(r_rsp_pc);
          end
        end
        IFU_DRAIN: if (w_outstanding_nxt == '0) w_state_nxt = IFU_RUN;
        IFU_HALT:  w_state_nxt = IFU_HALT;
        default:   w_state_nxt = IFU_RUN;
      endcase
    end
  end

  // State register, fetch PC, address of the next expected response, in-flight count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= IFU_RUN;
      r_fetch_pc    <= RESET_PC;
      r_rsp_pc      <= RESET_PC;
      r_outstanding <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_fetch_pc    <= w_fetch_pc_nxt;
      r_rsp_pc      <= w_rsp_pc_nxt;
      r_outstanding <= w_outstanding_nxt;
    end
  end

  ifu_fifo #(
    .W     ($bits(ifq_entry_t)),
    .DEPTH (QUEUE_DEPTH)
  ) u_queue (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_push     (w_push),
    .i_push_dat (w_push_dat),
    .i_pop      (w_pop),
    .i_flush    (redirect_valid),
    .o_full     (w_unused_full),
    .o_empty    (w_q_empty),
    .o_count    (w_q_count),
    .o_head_dat (w_head)
  );

  assign dec_valid = !w_q_empty;
  assign dec_inst  = w_q_empty ? '0 : w_head.inst;
  assign dec_pc    = w_q_empty ? '0 : w_head.pc;

`ifdef IFU_MISALIGN_CHECK_EN
  assign dec_fault = !w_q_empty && w_head.fault;
`else
  logic w_unused_fault;
  assign w_unused_fault = w_head.fault;
  assign dec_fault      = 1'b0;
`endif

endmodule

// File: tb/tb_instruction_fetch_unit.sv
module tb_instruction_fetch_unit;

  localparam int          DEPTH = 4;
  localparam logic [31:0] NOP   = 32'h0000_0013;
`ifdef IFU_MISALIGN_CHECK_EN
  localparam bit MIS_EN = 1'b1;
`else
  localparam bit MIS_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        imem_req_valid, imem_req_ready, imem_rsp_valid;
  logic [31:0] imem_addr, imem_rsp_data, redirect_pc, dec_inst, dec_pc;
  logic        redirect_valid, dec_valid, dec_ready, dec_fault;

  logic        wr_req_valid, wr_req_ready, wr_rsp_valid, wr_redirect_valid;
  logic        wr_dec_valid, wr_dec_ready, wr_dec_fault;
  logic [31:0] wr_addr, wr_rsp_data, wr_redirect_pc, wr_dec_inst, wr_dec_pc;

  instruction_fetch_unit #(.RESET_PC(32'h0000_0000), .QUEUE_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_addr(imem_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .dec_valid(dec_valid), .dec_ready(dec_ready), .dec_inst(dec_inst), .dec_pc(dec_pc),
    .dec_fault(dec_fault)
  );

  instruction_fetch_unit #(.RESET_PC(32'hFFFF_FFF8), .QUEUE_DEPTH(DEPTH)) dut_wrap (
    .clk(clk), .rst_n(rst_n),
    .imem_req_valid(wr_req_valid), .imem_req_ready(wr_req_ready), .imem_addr(wr_addr),
    .imem_rsp_valid(wr_rsp_valid), .imem_rsp_data(wr_rsp_data),
    .redirect_valid(wr_redirect_valid), .redirect_pc(wr_redirect_pc),
    .dec_valid(wr_dec_valid), .dec_ready(wr_dec_ready), .dec_inst(wr_dec_inst), .dec_pc(wr_dec_pc),
    .dec_fault(wr_dec_fault)
  );

  typedef struct packed { logic [31:0] pc; logic [31:0] inst; logic fault; } ent_t;
  typedef struct packed { logic [31:0] addr; logic stale; } pend_t;

  // Reference model: decode queue contents, outstanding requests with stale marks, fetch PC.
  ent_t        exp_q[$];
  pend_t       pend_q[$];
  logic [31:0] fpc;
  bit          halted;

  logic [31:0] acc_log[$];
  logic [31:0] wlog[$];
  int          checks, errors, cyc, first_acc, first_dec, rsp_mode;
  bit          spur_rsp;

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock cycle: memory drives its response, outputs are compared against the model,
  // then the model applies the cycle's events.
  task automatic tick();
    bit          exp_req, fire, rsp, pop, redir, mis, any_stale;
    logic [31:0] tgt;
    pend_t       p;
    if (spur_rsp) begin
      imem_rsp_valid = 1'b1; imem_rsp_data = 32'hDEAD_BEEF;
    end else if (pend_q.size() != 0 && (rsp_mode == 2 || (rsp_mode == 1 && $urandom_range(0, 1) == 1))) begin
      imem_rsp_valid = 1'b1; imem_rsp_data = word_of(pend_q[0].addr);
    end else begin
      imem_rsp_valid = 1'b0; imem_rsp_data = $urandom;
    end
    #1;
    any_stale = 1'b0;
    foreach (pend_q[i]) if (pend_q[i].stale) any_stale = 1'b1;
    exp_req = !halted && !any_stale && (pend_q.size() + exp_q.size() < DEPTH);
    chk("req_valid", 32'(imem_req_valid), 32'(exp_req));
    if (exp_req) chk("req_addr", imem_addr, fpc);
    chk("dec_valid", 32'(dec_valid), 32'(exp_q.size() != 0));
    if (exp_q.size() != 0) begin
      chk("dec_pc", dec_pc, exp_q[0].pc);
      chk("dec_fault", 32'(dec_fault), 32'(exp_q[0].fault));
      if (!exp_q[0].fault) chk("dec_inst", dec_inst, exp_q[0].inst);
    end else begin
      chk("idle_pc", dec_pc, 32'h0);
      chk("idle_inst", dec_inst, 32'h0);
      chk("idle_fault", 32'(dec_fault), 32'h0);
    end
    if (imem_req_valid && imem_req_ready) acc_log.push_back(imem_addr);
    if (wr_req_valid && wr_req_ready) wlog.push_back(wr_addr);
    if (imem_req_valid && imem_req_ready && first_acc < 0) first_acc = cyc;
    if (dec_valid && first_dec < 0) first_dec = cyc;
    fire  = exp_req && imem_req_ready;
    rsp   = imem_rsp_valid && pend_q.size() != 0;
    pop   = exp_q.size() != 0 && dec_ready;
    redir = redirect_valid;
    tgt   = redirect_pc;
    @(posedge clk);
    if (redir) begin
      mis = MIS_EN && (tgt[1:0] != 2'b00);
      if (!MIS_EN) tgt = tgt & ~32'h3;
      if (rsp) void'(pend_q.pop_front());
      foreach (pend_q[i]) pend_q[i].stale = 1'b1;
      if (fire) pend_q.push_back('{addr: fpc, stale: 1'b1});
      exp_q.delete();
      fpc = tgt;
      if (mis) begin
        exp_q.push_back('{pc: tgt, inst: NOP, fault: 1'b1});
        halted = 1'b1;
      end else begin
        halted = 1'b0;
      end
    end else begin
      if (pop) void'(exp_q.pop_front());
      if (rsp) begin
        p = pend_q.pop_front();
        if (!p.stale) exp_q.push_back('{pc: p.addr, inst: word_of(p.addr), fault: 1'b0});
      end
      if (fire) begin
        pend_q.push_back('{addr: fpc, stale: 1'b0});
        fpc = fpc + 32'd4;
      end
    end
    cyc++;
    @(negedge clk);
  endtask

  // Asynchronous mid-cycle reset; outputs must clear without waiting for a clock edge.
  task automatic do_reset();
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_req_valid", 32'(imem_req_valid), 32'h0);
    chk("rst_dec_valid", 32'(dec_valid), 32'h0);
    chk("rst_dec_inst", dec_inst, 32'h0);
    chk("rst_dec_pc", dec_pc, 32'h0);
    chk("rst_dec_fault", 32'(dec_fault), 32'h0);
    chk("rst_wrap_req", 32'(wr_req_valid), 32'h0);
    exp_q.delete(); pend_q.delete(); acc_log.delete(); wlog.delete();
    fpc = 32'h0; halted = 1'b0; cyc = 0; first_acc = -1; first_dec = -1;
    imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
    redirect_valid = 1'b0; redirect_pc = '0; dec_ready = 1'b0;
    rsp_mode = 0; spur_rsp = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_dec(input int budget);
    int n = 0;
    while (!dec_valid && n < budget) begin tick(); n++; end
    chk("dec_timeout", 32'(dec_valid), 32'h1);
  endtask

  initial begin
    checks = 0; errors = 0;
    wr_req_ready = 1'b1; wr_rsp_valid = 1'b0; wr_rsp_data = '0;
    wr_redirect_valid = 1'b0; wr_redirect_pc = '0; wr_dec_ready = 1'b1;

    // Reset and first fetches with a one-cycle memory; cycle 0 carries a pre-reset response.
    do_reset();
    imem_req_ready = 1'b1; dec_ready = 1'b1; rsp_mode = 2;
    spur_rsp = 1'b1; tick(); spur_rsp = 1'b0;
    repeat (9) tick();
    chk("seq_a0", acc_log[0], 32'h0);
    chk("seq_a1", acc_log[1], 32'h4);
    chk("seq_a2", acc_log[2], 32'h8);
    chk("seq_a3", acc_log[3], 32'hC);
    chk("first_acc_cyc", 32'(first_acc), 32'h0);
    chk("first_dec_cyc", 32'(first_dec), 32'h2);
    chk("wrap_n", 32'(wlog.size()), 32'h4);
    chk("wrap_a0", wlog[0], 32'hFFFF_FFF8);
    chk("wrap_a1", wlog[1], 32'hFFFF_FFFC);
    chk("wrap_a2", wlog[2], 32'h0000_0000);

    // Decode stalled: exactly QUEUE_DEPTH requests, then none until the first pop.
    do_reset();
    imem_req_ready = 1'b1; dec_ready = 1'b0; rsp_mode = 2;
    repeat (12) tick();
    chk("bp_reqs", 32'(acc_log.size()), 32'h4);
    chk("bp_hold", 32'(imem_req_valid), 32'h0);
    dec_ready = 1'b1; tick(); dec_ready = 1'b0;
    chk("bp_resume", 32'(imem_req_valid), 32'h1);
    tick();
    chk("bp_reqs5", 32'(acc_log.size()), 32'h5);

    // Redirect with two requests outstanding: both responses dropped.
    do_reset();
    imem_req_ready = 1'b1; dec_ready = 1'b1; rsp_mode = 0;
    repeat (2) tick();
    imem_req_ready = 1'b0;
    chk("rd_out2", 32'(acc_log.size()), 32'h2);
    redirect_valid = 1'b1; redirect_pc = 32'h40; tick(); redirect_valid = 1'b0;
    rsp_mode = 2; imem_req_ready = 1'b1;
    wait_dec(20);
    chk("rd_pc", dec_pc, 32'h40);
    chk("rd_inst", dec_inst, word_of(32'h40));

    // Redirect together with a pop on a full queue.
    do_reset();
    imem_req_ready = 1'b1; dec_ready = 1'b0; rsp_mode = 2;
    repeat (8) tick();
    chk("full_valid", 32'(dec_valid), 32'h1);
    redirect_valid = 1'b1; redirect_pc = 32'h100; dec_ready = 1'b1; tick(); redirect_valid = 1'b0;
    chk("rp_empty", 32'(dec_valid), 32'h0);
    wait_dec(20);
    chk("rp_pc", dec_pc, 32'h100);

    // Misaligned redirect target.
    do_reset();
    imem_req_ready = 1'b1; dec_ready = 1'b1; rsp_mode = 2;
    repeat (5) tick();
    redirect_valid = 1'b1; redirect_pc = 32'h42; tick(); redirect_valid = 1'b0;
`ifdef IFU_MISALIGN_CHECK_EN
    chk("mis_valid", 32'(dec_valid), 32'h1);
    chk("mis_fault", 32'(dec_fault), 32'h1);
    chk("mis_pc", dec_pc, 32'h42);
    begin
      int n0 = acc_log.size();
      repeat (10) tick();
      chk("mis_noreq", 32'(acc_log.size()), 32'(n0));
    end
    redirect_valid = 1'b1; redirect_pc = 32'h80; tick(); redirect_valid = 1'b0;
    wait_dec(20);
    chk("mis_exit_pc", dec_pc, 32'h80);
    chk("mis_exit_fault", 32'(dec_fault), 32'h0);
`else
    wait_dec(20);
    chk("align_pc", dec_pc, 32'h40);
    chk("align_fault", 32'(dec_fault), 32'h0);
`endif

    // Randomised traffic against the model.
    do_reset();
    rsp_mode = 1;
    for (int i = 0; i < 600; i++) begin
      imem_req_ready = ($urandom_range(0, 3) != 0);
      dec_ready      = ($urandom_range(0, 2) != 0);
      redirect_valid = ($urandom_range(0, 19) == 0);
      case ($urandom_range(0, 7))
        0:       redirect_pc = $urandom & 32'h0000_0FFF;
        1:       redirect_pc = $urandom & 32'hFFFF_FFFC;
        default: redirect_pc = $urandom & 32'h0000_0FFC;
      endcase
      tick();
    end
    redirect_valid = 1'b0;

    // Reset in the middle of traffic, then a leftover response from before it.
    do_reset();
    imem_req_ready = 1'b1; dec_ready = 1'b1; rsp_mode = 2;
    spur_rsp = 1'b1; tick(); spur_rsp = 1'b0;
    repeat (6) tick();
    chk("post_rst_a0", acc_log[0], 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
